// File: rtl/ann_pkg.sv
// ann_pkg: shared types and constants for the ANN MAC sequencer.
//   mac_state_t  : sequencer state encoding (IDLE, RUN, FINISH, DONE)
//   *_DEF        : default widths used by the interface and the top
//   INPUT_DELAY  : read latency of the operand memory, shared with the controller
//   sat_relu     : signed saturation to data_w bits with optional clamp of negatives
package ann_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } mac_state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int ACC_W_DEF     = 24;
    localparam int FRAC_BITS_DEF = 4;
    localparam int CNT_W_DEF     = 7;

    // Entries at the start of a pass whose operands are still in flight.
    localparam int INPUT_DELAY = 1;

    // Working width of the saturation helper; callers sign-extend into it.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] v,
        input int                      data_w,
        input bit                      relu_en
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        // Clamp happens after saturation so -2^(N-1) also maps to 0.
        if (relu_en && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ann_mac_sequencer_if.sv
// ann_mac_sequencer_if: controller <-> MAC sequencer bundle.
//   master : controller/memory side (drives start, enable, count and operands)
//   slave  : sequencer side (drives address, result, busy and done pulse)
interface ann_mac_sequencer_if #(
    parameter int DATA_W = ann_pkg::DATA_W_DEF,
    parameter int CNT_W  = ann_pkg::CNT_W_DEF
);
    logic                     reset_accum;
    logic                     coeff_ready;
    logic [CNT_W-1:0]         max_input;
    logic signed [DATA_W-1:0] data_in;
    logic signed [DATA_W-1:0] coef_in;
    logic [CNT_W-1:0]         rd_addr;
    logic signed [DATA_W-1:0] result;
    logic                     busy;
    logic                     n_start_done;

    modport master (
        output reset_accum, coeff_ready, max_input, data_in, coef_in,
        input  rd_addr, result, busy, n_start_done
    );

    modport slave (
        input  reset_accum, coeff_ready, max_input, data_in, coef_in,
        output rd_addr, result, busy, n_start_done
    );
endinterface

// File: rtl/ann_mac.sv
// ann_mac: signed multiply, sign-extend and registered accumulate.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of the accumulator (wins over en)
//   en       : add a*b into the accumulator this cycle
//   a, b     : signed operands
//   acc      : accumulator register, wraps modulo 2^ACC_W
module ann_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_reg;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + prod_ext;
        end
    end

    assign acc = acc_reg;
endmodule

// File: rtl/ann_mac_sequencer.sv
// ann_mac_sequencer: walks max_input entries of an activation/coefficient
// stream, accumulates their products and emits the scaled, saturated result.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : ann_mac_sequencer_if.slave
//              reset_accum (start), coeff_ready (advance), max_input (count
//              incl. one fill entry), data_in/coef_in (operands, 1-cycle
//              latency), rd_addr (entry index), result, busy, n_start_done
// Build option: define ANN_RELU_EN to clamp negative results to zero.
module ann_mac_sequencer
    import ann_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic                clk,
    input logic                rst,
    ann_mac_sequencer_if.slave bus
);
`ifdef ANN_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    mac_state_t               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         lim_reg;
    logic signed [DATA_W-1:0] result_reg;
    logic                     busy_reg;
    logic                     done_reg;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_shifted;
    logic signed [SAT_W-1:0]  acc_wide;
    logic signed [DATA_W-1:0] result_sat;
    logic                     mac_clr;
    logic                     mac_en;
    logic                     last_entry;

    // A limit of 0 or 1 means there is nothing to accumulate: the fill
    // entry alone ends the pass.
    assign last_entry = (lim_reg <= CNT_W'(1)) || (cnt_reg == lim_reg - CNT_W'(1));

    // Entries below INPUT_DELAY have no operands on the bus yet.
    assign mac_clr = bus.reset_accum;
    assign mac_en  = (state_reg == RUN) && bus.coeff_ready
                   && (cnt_reg >= CNT_W'(INPUT_DELAY));

    ann_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (bus.data_in),
        .b   (bus.coef_in),
        .acc (acc)
    );

    assign acc_shifted = acc >>> FRAC_BITS;
    assign acc_wide    = {{(SAT_W-ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted};
    assign result_sat  = DATA_W'(sat_relu(acc_wide, DATA_W, RELU_EN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            lim_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (bus.reset_accum) begin
            // Start (or restart from any state) a fresh pass.
            state_reg <= RUN;
            cnt_reg   <= '0;
            lim_reg   <= bus.max_input;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
                RUN: begin
                    if (bus.coeff_ready) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_entry) begin
                            state_reg <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    result_reg <= result_sat;
                    state_reg  <= DONE;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_addr      = cnt_reg;
    assign bus.result       = result_reg;
    assign bus.busy         = busy_reg;
    assign bus.n_start_done = done_reg;
endmodule

// File: doc/ann_mac_sequencer.md
# ann_mac_sequencer

Single-lane multiply-accumulate sequencer directly downstream of the ANN controller. When the controller pulses `reset_accum`, it walks an input/coefficient stream of `max_input` entries. It advances one entry per cycle while `coeff_ready` is high and emits the saturated (optionally rectified) neuron result. A one-cycle `n_start_done` pulse tells the controller the layer pass is finished.

## Interface
Parameters:
- `DATA_W`, 8: signed width of input activations, coefficients and result.
- `ACC_W`, 24: signed accumulator width.
- `FRAC_BITS`, 4: arithmetic right shift applied to the accumulator before saturation.
- `CNT_W`, 7: width of `max_input` and `rd_addr`.

Ports:
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `reset_accum`, in, 1: start pulse from the controller; clears the accumulator and counter.
- `coeff_ready`, in, 1: advance enable; low means stall.
- `max_input`, in, `CNT_W`: entry count including one pipeline-fill entry.
- `data_in`, in, `DATA_W`: activation at `rd_addr`, valid one cycle after the address.
- `coef_in`, in, `DATA_W`: coefficient at `rd_addr`, same timing as `data_in`.
- `rd_addr`, out, `CNT_W`: current entry index.
- `result`, out, `DATA_W`: final neuron value; held until the next start.
- `busy`, out, 1: high in RUN and FINISH.
- `n_start_done`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, FINISH, DONE. Outputs are Moore except `rd_addr`, which is the counter register.
- IDLE to RUN on `reset_accum`:
  - `cnt` is set to 0.
  - `acc` is set to 0.
  - `max_input` is latched into `lim`.
- RUN, on each cycle with `coeff_ready`=1:
  - Entry 0 is the fill cycle. Memory latency is 1, so the operands for entry k arrive during entry k+1.
  - For `cnt` ≥ 1, `acc += data_in*coef_in`, sign-extended to `ACC_W`. This accumulates the operands of entry `cnt-1`.
  - `cnt` increments.
  - When `cnt == lim-1` is consumed, go to FINISH.
- RUN with `coeff_ready`=0: hold everything.
- FINISH:
  - `result` = saturate(`acc >>> FRAC_BITS`) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Then go to DONE.
- DONE: `n_start_done`=1 for exactly one cycle, then go to IDLE.
- `lim` of 0 or 1: go RUN to FINISH on the first enabled cycle with `acc`=0. The result is 0.
- `reset_accum` in any state other than IDLE restarts the pass (same action as from IDLE).
  - From DONE: `n_start_done` still shows 1 that cycle.
- Accumulator overflow wraps modulo 2^`ACC_W`. `ACC_W` is sized so that 2*`DATA_W`+`CNT_W` ≤ `ACC_W`, so it cannot overflow in legal use.

## Timing
- Reset values:
  - state = IDLE
  - `cnt`, `lim`, `acc` = 0
  - `rd_addr` = 0
  - `result` = 0
  - `busy` = 0
  - `n_start_done` = 0
- Latency from the `reset_accum` cycle to the `n_start_done` cycle is `lim`+2 cycles with no stalls. Each stall cycle adds one.
- `rd_addr` changes only on enabled RUN cycles. Upstream memory must present the operands the following cycle whether or not a stall occurs.
- `result` updates on the FINISH to DONE edge. It is stable while `n_start_done` is high.

## Configuration
- `ANN_RELU_EN` defined: the FINISH step clamps negative values to 0 after saturation.
- `ANN_RELU_EN` undefined: the result is signed-saturated only, and negatives pass through.

## Structure
- Package `ann_pkg` holds:
  - the `mac_state_t` enum (IDLE, RUN, FINISH, DONE);
  - the default widths;
  - the `INPUT_DELAY`=1 constant shared with the controller.
- Sub-module `ann_mac` handles the combinational signed multiply and sign-extend. It also holds the registered accumulator, with `clr`/`en` inputs.
- Saturation and ReLU are a function in `ann_pkg`.

## Test plan
- Basic pass:
  - Stimulus: `max_input`=5; coefficients all 16; data 1,2,3,4 at addresses 1..4; `coeff_ready` high.
  - Response: `acc`=160, `result`=10, and `n_start_done` on cycle 7 after start.
- Stall:
  - Stimulus: the same vectors with `coeff_ready` low for 3 cycles mid-RUN.
  - Response: identical `result`=10; `n_start_done` is 3 cycles later and `rd_addr` is frozen during the stall.
- Saturation:
  - Stimulus: 64 entries of 127×127.
  - Response: `result`=127.
  - Stimulus: 64 entries of 127×(-128).
  - Response: `result`=-128 without `ANN_RELU_EN`, 0 with it.
- Degenerate count:
  - Stimulus: `max_input`=1.
  - Response: `result`=0, `n_start_done` at 3 cycles, no accumulation.
- Mid-pass restart:
  - Stimulus: `reset_accum` pulsed at cnt=3 of a 17-entry pass.
  - Response: `acc` cleared, a fresh 17-entry pass runs, and there is exactly one `n_start_done`.
- Async reset:
  - Stimulus: `rst` asserted mid-RUN between clock edges.
  - Response: all outputs are at their reset values immediately and the block sits in IDLE.
